// File: rtl/btn_debounce_pkg.sv
// Shared types and widths for the front-panel button debouncer.
package vm_btn_pkg;

    localparam int BTN_CNT_W = 8;
    localparam int BTN_RPT_W = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } lane_state_e;

endpackage

// File: rtl/btn_debounce_lane.sv
// One debounce lane: state machine, agreement counter and registered level/pulse outputs.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce_lane
    import vm_btn_pkg::*;
#(
    parameter int STABLE_TICKS = 4
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
`endif
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick,
    input  logic btn_s,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [BTN_CNT_W-1:0] CNT_ZERO = BTN_CNT_W'(0);
    localparam logic [BTN_CNT_W-1:0] CNT_ONE  = BTN_CNT_W'(1);
    localparam logic [BTN_CNT_W-1:0] CNT_LAST = BTN_CNT_W'(STABLE_TICKS - 1);
    localparam bit                   SINGLE   = (STABLE_TICKS == 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [BTN_RPT_W-1:0] RPT_ZERO   = BTN_RPT_W'(0);
    localparam logic [BTN_RPT_W-1:0] RPT_ONE    = BTN_RPT_W'(1);
    localparam logic [BTN_RPT_W-1:0] RPT_LAST   = BTN_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [BTN_RPT_W-1:0] RPT_RELOAD = BTN_RPT_W'(REPEAT_DELAY - REPEAT_RATE);
    logic [BTN_RPT_W-1:0] rpt_r;
`endif

    lane_state_e          state_r;
    logic [BTN_CNT_W-1:0] cnt_r;

    // Lane FSM; pulses default low so each lasts exactly one clk_in cycle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_r       <= RPT_ZERO;
`endif
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (tick) begin
                case (state_r)
                    IDLE: begin
                        if (btn_s && SINGLE) begin
                            state_r   <= HELD;
                            cnt_r     <= CNT_ZERO;
                            btn_level <= 1'b1;
                            btn_press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_r     <= RPT_ZERO;
`endif
                        end else if (btn_s) begin
                            state_r <= PRESS_WAIT;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            cnt_r <= CNT_ZERO;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!btn_s) begin
                            state_r <= IDLE;
                            cnt_r   <= CNT_ZERO;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r   <= HELD;
                            cnt_r     <= CNT_ZERO;
                            btn_level <= 1'b1;
                            btn_press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_r     <= RPT_ZERO;
`endif
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!btn_s && SINGLE) begin
                            state_r     <= IDLE;
                            cnt_r       <= CNT_ZERO;
                            btn_level   <= 1'b0;
                            btn_release <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_r       <= RPT_ZERO;
`endif
                        end else if (!btn_s) begin
                            state_r <= RELEASE_WAIT;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            cnt_r <= CNT_ZERO;
`ifdef BTN_AUTOREPEAT_EN
                            // Reload keeps later repeats REPEAT_RATE ticks apart.
                            if (rpt_r == RPT_LAST) begin
                                btn_press <= 1'b1;
                                rpt_r     <= RPT_RELOAD;
                            end else begin
                                rpt_r <= rpt_r + RPT_ONE;
                            end
`endif
                        end
                    end
                    RELEASE_WAIT: begin
                        if (btn_s) begin
                            state_r <= HELD;
                            cnt_r   <= CNT_ZERO;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r     <= IDLE;
                            cnt_r       <= CNT_ZERO;
                            btn_level   <= 1'b0;
                            btn_release <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_r       <= RPT_ZERO;
`endif
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Front-panel debouncer: input synchronizers, sample strobe edge detect and N_BTN lanes.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses while a button is held.
module btn_debounce
    import vm_btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sample_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] btn_s;
    logic             sample_clk_d_r;
    logic             tick_s;

    if (STABLE_TICKS < 1 || STABLE_TICKS > 255) begin : g_bad_stable
        $error("btn_debounce: STABLE_TICKS must be 1..255");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY || REPEAT_DELAY > 65535) begin : g_bad_repeat
        $error("btn_debounce: need 1 <= REPEAT_RATE <= REPEAT_DELAY <= 65535");
    end

    // Two-flop synchronizer per raw input plus the sample strobe history flop.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_r        <= '0;
            btn_s          <= '0;
            sample_clk_d_r <= 1'b0;
        end else begin
            sync1_r        <= btn_raw;
            btn_s          <= sync1_r;
            sample_clk_d_r <= sample_clk;
        end
    end

    assign tick_s = sample_clk & ~sample_clk_d_r;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_debounce_lane #(
            .STABLE_TICKS(STABLE_TICKS)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
`endif
        ) u_lane (
            .clk_in     (clk_in),
            .reset      (reset),
            .tick       (tick_s),
            .btn_s      (btn_s[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule
